stack_unit: RTL and testbench

Parametrised operand stack for the processor datapath, the successor to the fixed 256-bit push/pop stack. It adds multi-entry pop, pop-then-push for ALU results, DUP-n and SWAP-n through a registered deep-read port, a request handshake, and sticky underflow/overflow/illegal-op error reporting. It sits between the instruction decoder (requests) and the ALU (preview operands).

---
 rtl/stack_pkg.sv | 59 +++++
 rtl/stack_preview_mux.sv | 23 ++
 rtl/stack_unit.sv | 174 +++++++++++++++++
 tb/tb_stack_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the operand stack.
// The classify() helper decides the error outcome of a request against the current sp.
package stack_pkg;

    localparam int ARG_W   = 5;
    localparam int MAX_DUP = 16;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_POP_PUSH = 3'd3,
        OP_DUP      = 3'd4,
        OP_SWAP     = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    // POP_PUSH cannot overflow: arg=0 on a full stack replaces the top entry.
    function automatic logic [1:0] classify(input logic [2:0] op, input int arg,
                                            input int sp, input int depth,
                                            input int max_pop);
        logic [1:0] code;
        code = ERR_NONE;
        case (op_e'(op))
            OP_NOP:      code = ERR_NONE;
            OP_PUSH:     code = (sp + 1 > depth) ? ERR_OVERFLOW : ERR_NONE;
            OP_POP: begin
                if (arg == 0 || arg > max_pop) code = ERR_ILLEGAL;
                else if (arg > sp)             code = ERR_UNDERFLOW;
            end
            OP_POP_PUSH: begin
                if (arg > max_pop)  code = ERR_ILLEGAL;
                else if (arg > sp)  code = ERR_UNDERFLOW;
            end
            OP_DUP: begin
                if (arg == 0 || arg > MAX_DUP) code = ERR_ILLEGAL;
                else if (arg > sp)             code = ERR_UNDERFLOW;
                else if (sp + 1 > depth)       code = ERR_OVERFLOW;
            end
            OP_SWAP: begin
                if (arg == 0 || arg > MAX_DUP) code = ERR_ILLEGAL;
                else if (arg + 1 > sp)         code = ERR_UNDERFLOW;
            end
            default:     code = ERR_ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stack_preview_mux.sv
// Exposes the top PREVIEW_DEPTH stack entries; slice i is entry sp-1-i, zero when i >= sp.
module stack_preview_mux #(
    parameter int WIDTH         = 256,
    parameter int DEPTH         = 1024,
    parameter int PREVIEW_DEPTH = 2
) (
    input  logic [WIDTH-1:0]               mem_i [DEPTH],
    input  logic [$clog2(DEPTH+1)-1:0]     sp_i,
    output logic [PREVIEW_DEPTH*WIDTH-1:0] preview_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    always_comb begin
        preview_o = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (i < int'(sp_i)) begin
                preview_o[i*WIDTH +: WIDTH] = mem_i[AW'(int'(sp_i) - 1 - i)];
            end
        end
    end

endmodule

// File: rtl/stack_unit.sv
// Operand stack with multi-pop, pop-then-push, DUP-n/SWAP-n via a registered deep read,
// request handshake and sticky first-error reporting.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH         = 256,
    parameter int DEPTH         = 1024,
    parameter int PREVIEW_DEPTH = 2,
    parameter int MAX_POP       = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [2:0]                     req_op,
    input  logic [ARG_W-1:0]               req_arg,
    input  logic [WIDTH-1:0]               req_data,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     err_code,
    output logic [PREVIEW_DEPTH*WIDTH-1:0] preview,
    output logic [$clog2(DEPTH+1)-1:0]     size,
    output logic                           empty,
    output logic                           full
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    op_e              op_q, op_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] rd_q;

    logic             rd_en, wr0_en, wr1_en;
    logic [AW-1:0]    rd_idx, wr0_idx, wr1_idx;
    logic [WIDTH-1:0] wr0_data, wr1_data;
    logic [1:0]       chk;
    int               sp_i, arg_i, n_i;

    always_comb begin
        sp_i       = int'(sp_q);
        arg_i      = int'(req_arg);
        n_i        = int'(arg_q);
        state_d    = state_q;
        sp_d       = sp_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        op_d       = op_q;
        arg_d      = arg_q;
        rd_en      = 1'b0;
        rd_idx     = '0;
        wr0_en     = 1'b0;
        wr0_idx    = '0;
        wr0_data   = req_data;
        wr1_en     = 1'b0;
        wr1_idx    = '0;
        wr1_data   = rd_q;
        chk        = classify(req_op, arg_i, sp_i, DEPTH, MAX_POP);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (chk != ERR_NONE) begin
                        done_d = 1'b1;
                        if (!err_q) begin
                            err_d      = 1'b1;
                            err_code_d = chk;
                        end
                    end else begin
                        case (op_e'(req_op))
                            OP_PUSH: begin
                                wr0_en  = 1'b1;
                                wr0_idx = AW'(sp_i);
                                sp_d    = SP_W'(sp_i + 1);
                                done_d  = 1'b1;
                            end
                            OP_POP: begin
                                sp_d   = SP_W'(sp_i - arg_i);
                                done_d = 1'b1;
                            end
                            OP_POP_PUSH: begin
                                wr0_en = 1'b1;
                                done_d = 1'b1;
                                if (arg_i == 0 && sp_i == DEPTH) begin
                                    wr0_idx = AW'(sp_i - 1);
                                end else begin
                                    wr0_idx = AW'(sp_i - arg_i);
                                    sp_d    = SP_W'(sp_i - arg_i + 1);
                                end
                            end
                            OP_DUP, OP_SWAP: begin
                                state_d = ST_READ;
                                op_d    = op_e'(req_op);
                                arg_d   = req_arg;
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                rd_idx  = (op_q == OP_DUP) ? AW'(sp_i - n_i) : AW'(sp_i - 1 - n_i);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr0_en  = 1'b1;
                state_d = ST_IDLE;
                if (op_q == OP_DUP) begin
                    wr0_idx  = AW'(sp_i);
                    wr0_data = rd_q;
                    sp_d     = SP_W'(sp_i + 1);
                end else begin
                    wr0_idx  = AW'(sp_i - 1 - n_i);
                    wr0_data = mem_q[AW'(sp_i - 1)];
                    wr1_en   = 1'b1;
                    wr1_idx  = AW'(sp_i - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sp_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Storage and the deep-read register carry no reset; rst only suppresses writes.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        arg_q <= arg_d;
        if (rd_en) rd_q <= mem_q[rd_idx];
        if (!rst && wr0_en) mem_q[wr0_idx] <= wr0_data;
        if (!rst && wr1_en) mem_q[wr1_idx] <= wr1_data;
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign done      = !rst && (done_q || state_q == ST_WRITE);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign size      = sp_q;
    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SP_W'(DEPTH));

    stack_preview_mux #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .PREVIEW_DEPTH(PREVIEW_DEPTH)
    ) u_preview (
        .mem_i    (mem_q),
        .sp_i     (sp_q),
        .preview_o(preview)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Directed table-driven bench for stack_unit (WIDTH=16, DEPTH=8), plus DUP latency and reset-abort sequences.
module tb_stack_unit;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PP = 3'd3, DUP = 3'd4, SWAP = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_arg;
    logic [15:0] req_data;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] preview;
    logic [3:0]  size;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stack_unit #(
        .WIDTH(16), .DEPTH(8), .PREVIEW_DEPTH(2), .MAX_POP(7)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_arg(req_arg), .req_data(req_data), .done(done),
        .err(err), .err_code(err_code), .preview(preview), .size(size),
        .empty(empty), .full(full)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [2:0]  op;
        logic [4:0]  arg;
        logic [15:0] data;
        logic        e_done;
        logic        e_rdy;
        int          e_size;
        logic [15:0] e_p0;
        logic [15:0] e_p1;
        logic        e_err;
        logic [1:0]  e_ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] op,
                                input logic [4:0] arg, input logic [15:0] data,
                                input logic e_done, input logic e_rdy, input int e_size,
                                input logic [15:0] e_p0, input logic [15:0] e_p1,
                                input logic e_err, input logic [1:0] e_ec);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.arg = arg; t.data = data;
        t.e_done = e_done; t.e_rdy = e_rdy; t.e_size = e_size;
        t.e_p0 = e_p0; t.e_p1 = e_p1; t.e_err = e_err; t.e_ec = e_ec;
        return t;
    endfunction

    // Packs {done, ready, size, empty, full, top, next, err, err_code}.
    function automatic logic [63:0] expv(input logic d, input logic rdy, input int sz,
                                         input logic [15:0] p0, input logic [15:0] p1,
                                         input logic e, input logic [1:0] ec);
        return {21'd0, d, rdy, 4'(sz), (sz == 0), (sz == 8), p0, p1, e, ec};
    endfunction

    function automatic logic [63:0] obs();
        return {21'd0, done, req_ready, size, empty, full, preview[15:0], preview[31:16], err, err_code};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                       input logic [4:0] arg, input logic [15:0] d);
        @(negedge clk);
        rst = r; req_valid = v; req_op = op; req_arg = arg; req_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = NOP; req_arg = '0; req_data = '0;

        vecs.push_back(mk(1, 0, NOP,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0011, 1, 1, 1, 16'h0011, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0022, 1, 1, 2, 16'h0022, 16'h0011, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0033, 1, 1, 3, 16'h0033, 16'h0022, 0, 0));
        vecs.push_back(mk(0, 1, PP,   2, 16'h00AA, 1, 1, 2, 16'h00AA, 16'h0011, 0, 0));
        vecs.push_back(mk(0, 1, POP,  1, 16'h0000, 1, 1, 1, 16'h0011, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0022, 1, 1, 2, 16'h0022, 16'h0011, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0033, 1, 1, 3, 16'h0033, 16'h0022, 0, 0));
        vecs.push_back(mk(0, 1, DUP,  3, 16'h0000, 0, 0, 3, 16'h0033, 16'h0022, 0, 0));
        vecs.push_back(mk(0, 0, NOP,  0, 16'h0000, 1, 0, 3, 16'h0033, 16'h0022, 0, 0));
        vecs.push_back(mk(0, 0, NOP,  0, 16'h0000, 0, 1, 4, 16'h0011, 16'h0033, 0, 0));
        vecs.push_back(mk(0, 1, SWAP, 2, 16'h0000, 0, 0, 4, 16'h0011, 16'h0033, 0, 0));
        vecs.push_back(mk(0, 0, NOP,  0, 16'h0000, 1, 0, 4, 16'h0011, 16'h0033, 0, 0));
        vecs.push_back(mk(0, 0, NOP,  0, 16'h0000, 0, 1, 4, 16'h0022, 16'h0033, 0, 0));
        vecs.push_back(mk(0, 1, POP,  2, 16'h0000, 1, 1, 2, 16'h0011, 16'h0011, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0044, 1, 1, 3, 16'h0044, 16'h0011, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0055, 1, 1, 4, 16'h0055, 16'h0044, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0066, 1, 1, 5, 16'h0066, 16'h0055, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0077, 1, 1, 6, 16'h0077, 16'h0066, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0088, 1, 1, 7, 16'h0088, 16'h0077, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'h0099, 1, 1, 8, 16'h0099, 16'h0088, 0, 0));
        vecs.push_back(mk(0, 1, PUSH, 0, 16'hBEEF, 1, 1, 8, 16'h0099, 16'h0088, 1, 2));
        vecs.push_back(mk(0, 1, POP,  9, 16'h0000, 1, 1, 8, 16'h0099, 16'h0088, 1, 2));
        vecs.push_back(mk(0, 1, PP,   0, 16'h00CD, 1, 1, 8, 16'h00CD, 16'h0088, 1, 2));
        vecs.push_back(mk(0, 1, NOP,  0, 16'h0000, 1, 1, 8, 16'h00CD, 16'h0088, 1, 2));
        vecs.push_back(mk(0, 0, NOP,  0, 16'h0000, 0, 1, 8, 16'h00CD, 16'h0088, 1, 2));
        vecs.push_back(mk(1, 0, NOP,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, POP,  1, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 1, 1));
        vecs.push_back(mk(1, 0, NOP,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 3'd7, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 1, 3));
        vecs.push_back(mk(1, 0, NOP,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].data);
            check($sformatf("vec%0d", i), obs(),
                  expv(vecs[i].e_done, vecs[i].e_rdy, vecs[i].e_size, vecs[i].e_p0,
                       vecs[i].e_p1, vecs[i].e_err, vecs[i].e_ec));
        end

        // DUP 2 on {0x11,0x22}: two not-ready cycles, done in the second, copy of 0x11 on top.
        cyc(0, 1, PUSH, 0, 16'h0011);
        check("dup_push1", obs(), expv(1, 1, 1, 16'h0011, 16'h0000, 0, 0));
        cyc(0, 1, PUSH, 0, 16'h0022);
        check("dup_push2", obs(), expv(1, 1, 2, 16'h0022, 16'h0011, 0, 0));
        cyc(0, 1, DUP, 2, 16'h0000);
        check("dup_read", obs(), expv(0, 0, 2, 16'h0022, 16'h0011, 0, 0));
        cyc(0, 0, NOP, 0, 16'h0000);
        check("dup_write", obs(), expv(1, 0, 2, 16'h0022, 16'h0011, 0, 0));
        cyc(0, 0, NOP, 0, 16'h0000);
        check("dup_after", obs(), expv(0, 1, 3, 16'h0011, 16'h0022, 0, 0));

        // Reset asserted while a DUP sits in READ: no done, stack empties, ready once rst drops.
        cyc(0, 1, DUP, 1, 16'h0000);
        check("abort_read", obs(), expv(0, 0, 3, 16'h0011, 16'h0022, 0, 0));
        cyc(1, 0, NOP, 0, 16'h0000);
        check("abort_rst", obs(), expv(0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        cyc(0, 0, NOP, 0, 16'h0000);
        check("abort_ready", obs(), expv(0, 1, 0, 16'h0000, 16'h0000, 0, 0));
        cyc(0, 0, NOP, 0, 16'h0000);
        check("abort_quiet", obs(), expv(0, 1, 0, 16'h0000, 16'h0000, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
